// File: rtl/tp2_pkg.sv
// Shared types and constants for the TP2 UART/ALU frame path.
// Opcode set, error byte and frame FSM encoding.
package tp2_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int OP_WIDTH   = 6;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  function automatic logic is_valid_op(input logic [5:0] op);
    logic v;
    v = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts while enabled, flags expiry
// on the last cycle of the window unless cleared that cycle.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 52260,
  parameter int W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Frame layer: collects A, B, opcode from the UART receiver,
// registers the ALU result and hands it to the transmitter.
module uart_alu_interface
  import tp2_pkg::*;
#(
  parameter int DATA_WIDTH     = tp2_pkg::DATA_WIDTH,
  parameter int OP_WIDTH       = tp2_pkg::OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 52260
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_overrun
);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_start;
  logic                  r_err;
  logic                  r_overrun;
  logic                  r_inv;

  logic w_cnt_en;
  logic w_expire;
  logic w_drop;
  logic w_bad_op;

  assign w_cnt_en = (r_state == S_GET_B) || (r_state == S_GET_OP);

  assign w_drop = i_rx_done &&
                  ((r_state == S_EXEC) ||
                   (r_state == S_SEND) ||
                   (r_state == S_WAIT_TX));

  assign w_bad_op =
    (i_rx_data[DATA_WIDTH-1:OP_WIDTH] != '0) ||
    !is_valid_op(i_rx_data[5:0]);

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_clear (i_rx_done),
    .i_en    (w_cnt_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_overrun  <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_overrun  <= w_drop;
      unique case (r_state)
        S_IDLE: begin
          if (i_rx_done) begin
            r_alu_a <= i_rx_data;
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (i_rx_done) begin
            r_alu_b <= i_rx_data;
            r_state <= S_GET_OP;
          end else if (w_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_GET_OP: begin
          if (i_rx_done) begin
            r_alu_op <= i_rx_data[OP_WIDTH-1:0];
            r_inv    <= w_bad_op;
            r_state  <= S_EXEC;
          end else if (w_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_tx_data  <= r_inv ? ERR_BYTE : i_alu_result;
          r_err      <= r_inv;
          r_tx_start <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          r_state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_tx_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_err      = r_err;
  assign o_overrun  = r_overrun;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a behavioural
// ALU model wired like the sibling ALU in the system top.
module tb_uart_alu_interface;

  localparam int TMO = 40;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_done = 1'b0;
  logic       o_busy;
  logic       o_err;
  logic       o_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_err   = 0;
  int n_ovr   = 0;

  uart_alu_interface #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .i_alu_result(i_alu_result),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_overrun   (o_overrun)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    i_alu_result = 8'h00;
    case (o_alu_op)
      6'h20: i_alu_result = o_alu_a + o_alu_b;
      6'h22: i_alu_result = o_alu_a - o_alu_b;
      6'h24: i_alu_result = o_alu_a & o_alu_b;
      6'h25: i_alu_result = o_alu_a | o_alu_b;
      6'h26: i_alu_result = o_alu_a ^ o_alu_b;
      6'h27: i_alu_result = ~(o_alu_a | o_alu_b);
      6'h03: i_alu_result = $unsigned($signed(o_alu_a) >>> o_alu_b);
      6'h02: i_alu_result = o_alu_a >> o_alu_b;
      default: i_alu_result = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (o_tx_start) n_start <= n_start + 1;
    if (o_err)      n_err   <= n_err + 1;
    if (o_overrun)  n_ovr   <= n_ovr + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge CLK);
    i_rx_done = 1'b0;
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] op,
                       input logic [7:0] exp);
    int s0;
    s0 = n_start;
    @(negedge CLK);
    send(a);
    send(b);
    send(op);
    chk({tag, "_busy_exec"}, o_busy, 1);
    chk({tag, "_nostart_exec"}, o_tx_start, 0);
    @(negedge CLK);
    chk({tag, "_start"}, o_tx_start, 1);
    chk({tag, "_data"}, o_tx_data, exp);
    @(negedge CLK);
    chk({tag, "_start_1cyc"}, o_tx_start, 0);
    chk({tag, "_hold"}, o_tx_data, exp);
    chk({tag, "_busy_wait"}, o_busy, 1);
    chk({tag, "_one_start"}, n_start - s0, 1);
  endtask

  task automatic tx_finish(input string tag);
    i_tx_done = 1'b1;
    @(negedge CLK);
    i_tx_done = 1'b0;
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    int e0;
    int o0;
    int s0;

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_a", o_alu_a, 0);
    chk("rst_tx", o_tx_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_tx_start, 0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // 1: SUB
    frame("sub", 8'h32, 8'h2D, 8'h22, 8'h05);
    tx_finish("sub");

    // 2: ADD wraps, no error
    e0 = n_err;
    frame("add", 8'hF0, 8'h20, 8'h20, 8'h10);
    tx_finish("add");
    chk("add_noerr", n_err - e0, 0);

    // 3: partial frame dropped by timeout
    s0 = n_start;
    @(negedge CLK);
    send(8'h11);
    send(8'h22);
    repeat (TMO - 2) @(negedge CLK);
    chk("tmo_still_busy", o_busy, 1);
    repeat (3) @(negedge CLK);
    chk("tmo_idle", o_busy, 0);
    frame("tmo_add", 8'h05, 8'h03, 8'h20, 8'h08);
    tx_finish("tmo_add");
    chk("tmo_starts", n_start - s0, 1);

    // 4: invalid opcodes
    e0 = n_err;
    frame("inv3f", 8'h01, 8'h02, 8'h3F, 8'hEE);
    tx_finish("inv3f");
    chk("inv3f_err", n_err - e0, 1);
    e0 = n_err;
    frame("invA0", 8'h01, 8'h02, 8'hA0, 8'hEE);
    tx_finish("invA0");
    chk("invA0_err", n_err - e0, 1);

    // 5: overrun in WAIT_TX, then OR frame
    frame("ovr_sub", 8'h32, 8'h2D, 8'h22, 8'h05);
    o0 = n_ovr;
    send(8'h55);
    chk("ovr_pulse", o_overrun, 1);
    chk("ovr_busy", o_busy, 1);
    chk("ovr_hold", o_tx_data, 8'h05);
    @(negedge CLK);
    chk("ovr_1cyc", o_overrun, 0);
    chk("ovr_count", n_ovr - o0, 1);
    tx_finish("ovr_sub");
    frame("or", 8'h0F, 8'hF0, 8'h25, 8'hFF);

    // tx_done and rx_done together: byte dropped, go idle
    i_tx_done = 1'b1;
    i_rx_data = 8'h99;
    i_rx_done = 1'b1;
    @(negedge CLK);
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    chk("coinc_idle", o_busy, 0);
    chk("coinc_ovr", o_overrun, 1);
    chk("coinc_a_kept", o_alu_a, 8'h0F);

    // 6: async reset in GET_OP
    @(negedge CLK);
    send(8'h77);
    send(8'h66);
    chk("pre_rst_busy", o_busy, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_a", o_alu_a, 0);
    chk("arst_b", o_alu_b, 0);
    chk("arst_tx", o_tx_data, 0);
    chk("arst_busy", o_busy, 0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    frame("srl", 8'h04, 8'h01, 8'h02, 8'h02);
    tx_finish("srl");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
